// File: rtl/shake_pkg.sv
// Shared types and constants for the SHAKE sponge controller.
package shake_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ABSORB,
        ST_PERMUTE,
        ST_SQUEEZE,
        ST_DONE
    } sponge_state_t;

    localparam int RATE128_LANES = 21;
    localparam int RATE256_LANES = 17;
    localparam int LANE_W        = 64;
    localparam int NUM_LANES     = 25;

    // Lanes per block: mode 0 = SHAKE128, mode 1 = SHAKE256.
    function automatic logic [4:0] rate_lanes(input logic mode);
        return mode ? 5'(RATE256_LANES) : 5'(RATE128_LANES);
    endfunction

endpackage

// File: rtl/sponge_ctrl_if.sv
// Control/handshake bundle between the sponge controller and its surroundings.
// Handshakes: a lane transfers on a rising clk edge where valid && ready are both high.
interface sponge_ctrl_if #(parameter int OUTW = 16) ();
    import shake_pkg::*;

    logic              start;
    logic              mode;
    logic [OUTW-1:0]   out_words;
    logic              in_valid;
    logic              in_last;
    logic              in_ready;
    logic              out_valid;
    logic              out_ready;
    logic              state_clr;
    logic              state_en;
    logic              absorb_en;
    logic              perm_en;
    logic [4:0]        lane_idx;
    logic [4:0]        round_idx;
    logic              busy;
    logic              done;
    sponge_state_t     fsm_state;

    modport slave (
        input  start, mode, out_words, in_valid, in_last, out_ready,
        output in_ready, out_valid, state_clr, state_en, absorb_en, perm_en,
               lane_idx, round_idx, busy, done, fsm_state
    );

    modport master (
        output start, mode, out_words, in_valid, in_last, out_ready,
        input  in_ready, out_valid, state_clr, state_en, absorb_en, perm_en,
               lane_idx, round_idx, busy, done, fsm_state
    );

endinterface

// File: rtl/mod_counter.sv
// Up-counter that wraps to zero after reaching max; clear wins over enable.
module mod_counter #(
    parameter int W = 5
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         en,
    input  logic [W-1:0] max,
    output logic [W-1:0] count
);

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            count <= '0;
        end else if (en) begin
            count <= (count == max) ? '0 : count + W'(1);
        end
    end

endmodule

// File: rtl/regn.sv
// Plain enabled register with synchronous active-high reset.
module regn #(
    parameter int W = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    always_ff @(posedge clk) begin
        if (rst) begin
            q <= '0;
        end else if (en) begin
            q <= d;
        end
    end

endmodule

// File: rtl/sponge_ctrl.sv
// Absorb/permute/squeeze sequencer for the SHAKE128/256 sponge datapath.
module sponge_ctrl
    import shake_pkg::*;
#(
    parameter int ROUNDS = 24,
    parameter int OUTW   = 16
) (
    input  logic         clk,
    input  logic         rst,
    sponge_ctrl_if.slave sif
);

    sponge_state_t   state, state_nx;
    logic            mode_q;
    logic [OUTW-1:0] words_q;
    logic [OUTW-1:0] sent_q;
    logic [OUTW-1:0] remaining;
    logic [4:0]      lane;
    logic [4:0]      round;
    logic [4:0]      rate_m1;
    logic            last_blk;

    logic start_acc, in_hs, out_hs, blk_end, perm_last;
    logic in_ready, out_valid, state_clr, state_en, absorb_en, perm_en, busy, done;

    assign start_acc = (state == ST_IDLE) && sif.start;
    assign in_hs     = (state == ST_ABSORB) && sif.in_valid;
    assign out_hs    = (state == ST_SQUEEZE) && sif.out_ready;
    assign blk_end   = in_hs && ((lane == rate_m1) || sif.in_last);
    assign perm_last = (state == ST_PERMUTE) && (round == 5'(ROUNDS - 1));
    assign rate_m1   = rate_lanes(mode_q) - 5'd1;
    // Outstanding lanes; sent_q stops at words_q so this cannot wrap.
    assign remaining = words_q - sent_q;

    regn #(.W(1)) u_mode (
        .clk (clk), .rst (rst), .en (start_acc), .d (sif.mode), .q (mode_q)
    );

    regn #(.W(OUTW)) u_words (
        .clk (clk), .rst (rst), .en (start_acc), .d (sif.out_words), .q (words_q)
    );

    mod_counter #(.W(5)) u_lane (
        .clk   (clk),
        .rst   (rst),
        .clr   (start_acc || blk_end),
        .en    (in_hs || out_hs),
        .max   (rate_m1),
        .count (lane)
    );

    mod_counter #(.W(5)) u_round (
        .clk   (clk),
        .rst   (rst),
        .clr   (blk_end),
        .en    (state == ST_PERMUTE),
        .max   (5'(ROUNDS - 1)),
        .count (round)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ST_IDLE;
            sent_q   <= '0;
            last_blk <= 1'b0;
        end else begin
            state <= state_nx;
            if (start_acc) begin
                sent_q <= '0;
            end else if (out_hs) begin
                sent_q <= sent_q + OUTW'(1);
            end
            if (blk_end) begin
                last_blk <= sif.in_last;
            end
        end
    end

    always_comb begin
        state_nx  = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        state_clr = 1'b0;
        state_en  = 1'b0;
        absorb_en = 1'b0;
        perm_en   = 1'b0;
        busy      = 1'b1;
        done      = 1'b0;
        case (state)
            ST_IDLE: begin
                busy = 1'b0;
                if (sif.start) begin
                    state_clr = 1'b1;
                    state_en  = 1'b1;
                    state_nx  = ST_ABSORB;
                end
            end
            ST_ABSORB: begin
                in_ready = 1'b1;
                if (sif.in_valid) begin
                    absorb_en = 1'b1;
                    state_en  = 1'b1;
                    if (blk_end) state_nx = ST_PERMUTE;
                end
            end
            ST_PERMUTE: begin
                perm_en  = 1'b1;
                state_en = 1'b1;
                if (perm_last) begin
                    if (!last_blk)            state_nx = ST_ABSORB;
                    else if (remaining == '0) state_nx = ST_DONE;
                    else                      state_nx = ST_SQUEEZE;
                end
            end
            ST_SQUEEZE: begin
                out_valid = 1'b1;
                // Rate exhausted with lanes still owed: re-permute, then resume at lane 0.
                if (sif.out_ready) begin
                    if (remaining == OUTW'(1))  state_nx = ST_DONE;
                    else if (lane == rate_m1)   state_nx = ST_PERMUTE;
                end
            end
            ST_DONE: begin
                done     = 1'b1;
                state_nx = ST_IDLE;
            end
            default: state_nx = ST_IDLE;
        endcase
    end

    assign sif.in_ready  = in_ready;
    assign sif.out_valid = out_valid;
    assign sif.state_clr = state_clr;
    assign sif.state_en  = state_en;
    assign sif.absorb_en = absorb_en;
    assign sif.perm_en   = perm_en;
    assign sif.lane_idx  = lane;
    assign sif.round_idx = round;
    assign sif.busy      = busy;
    assign sif.done      = done;
    assign sif.fsm_state = state;

endmodule
